disp_decoder: RTL and testbench

DISP_DECODER -- requirements
Module: disp_decoder

---
 rtl/disp_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_disp_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/disp_decoder.sv
// Serial 7-segment frame receiver: decodes a digit 0..5 into free/busy machine counts
// and delivers it through a valid/ready hold register with per-frame error pulses.
module disp_decoder #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seg_in,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [6:0] seg_code,
    output logic [2:0] free_cnt,
    output logic [2:0] busy_cnt,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_code,
    output logic       overrun
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      data_q, data_d;
    logic            par_q, par_d;
    logic            stop_q, stop_d;
    logic            armed_q, armed_d;
    logic            valid_q, valid_d;
    logic [6:0]      code_q, code_d;
    logic [2:0]      free_q, free_d;
    logic [2:0]      busy_q, busy_d;
    logic            err_parity_q, err_parity_d;
    logic            err_frame_q, err_frame_d;
    logic            err_code_q, err_code_d;
    logic            overrun_q, overrun_d;

    logic       line;
    logic       bit_tick;
    logic       par_bad;
    logic       stop_bad;
    logic [3:0] dec;

    // Returns {hit, digit}.
    function automatic logic [3:0] decode(input logic [6:0] pat);
        logic [3:0] r;
        case (pat)
            7'b1111110: r = {1'b1, 3'd0};
            7'b0110000: r = {1'b1, 3'd1};
            7'b1101101: r = {1'b1, 3'd2};
            7'b1111001: r = {1'b1, 3'd3};
            7'b0110011: r = {1'b1, 3'd4};
            7'b1011011: r = {1'b1, 3'd5};
            default:    r = 4'b0000;
        endcase
        return r;
    endfunction

    assign line     = sync2_q;
    assign bit_tick = (cnt_q == LastCnt);
    assign par_bad  = ^{data_q, par_q};
    assign stop_bad = ~stop_q;
    assign dec      = decode(data_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            armed_q      <= 1'b1;
            valid_q      <= 1'b0;
            code_q       <= '0;
            free_q       <= '0;
            busy_q       <= '0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            err_code_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync1_q      <= seg_in;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            armed_q      <= armed_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            free_q       <= free_d;
            busy_q       <= busy_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
            err_code_q   <= err_code_d;
            overrun_q    <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        data_d       = data_q;
        par_d        = par_q;
        stop_d       = stop_q;
        armed_d      = armed_q | line;
        valid_d      = valid_q;
        code_d       = code_q;
        free_d       = free_q;
        busy_d       = busy_q;
        err_parity_d = 1'b0;
        err_frame_d  = 1'b0;
        err_code_d   = 1'b0;
        overrun_d    = 1'b0;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                // A line stuck low after a bad stop bit must go high before it can start a frame.
                if (!line && armed_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HalfCnt) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = line ? StIdle : StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_tick) begin
                    cnt_d  = '0;
                    data_d = {data_q[5:0], line};
                    idx_d  = idx_q + 3'd1;
                    if (idx_q == 3'd6) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_tick) begin
                    cnt_d   = '0;
                    par_d   = line;
                    state_d = StStop;
                end
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_tick) begin
                    cnt_d   = '0;
                    stop_d  = line;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d      = StIdle;
                err_parity_d = par_bad;
                err_frame_d  = stop_bad;
                err_code_d   = !par_bad && !stop_bad && !dec[3];
                if (stop_bad) begin
                    armed_d = 1'b0;
                end
                if (!par_bad && !stop_bad && dec[3]) begin
                    if (!valid_q || out_ready) begin
                        valid_d = 1'b1;
                        code_d  = data_q;
                        free_d  = dec[2:0];
                        busy_d  = 3'd5 - dec[2:0];
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign out_valid  = valid_q;
    assign seg_code   = code_q;
    assign free_cnt   = free_q;
    assign busy_cnt   = busy_q;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign err_code   = err_code_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_disp_decoder.sv
// Scoreboard bench for disp_decoder: directed frames push expected events, a monitor
// pops and compares every handshake and error pulse.
`timescale 1ns/1ps
module tb_disp_decoder;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       seg_in;
    logic       out_ready;
    logic       out_valid;
    logic [6:0] seg_code;
    logic [2:0] free_cnt;
    logic [2:0] busy_cnt;
    logic       err_parity;
    logic       err_frame;
    logic       err_code;
    logic       overrun;

    typedef struct packed {
        logic       kind;  // 0 = result, 1 = error pulses
        logic [6:0] seg;
        logic [2:0] free;
        logic [2:0] busy;
        logic [3:0] errs;  // {parity, frame, code, overrun}
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    disp_decoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .seg_code  (seg_code),
        .free_cnt  (free_cnt),
        .busy_cnt  (busy_cnt),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .err_code  (err_code),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic ev_t res_ev(input logic [6:0] seg, input logic [2:0] free);
        ev_t e;
        e      = '0;
        e.seg  = seg;
        e.free = free;
        e.busy = 3'd5 - free;
        return e;
    endfunction

    function automatic ev_t err_ev(input logic [3:0] errs);
        ev_t e;
        e      = '0;
        e.kind = 1'b1;
        e.errs = errs;
        return e;
    endfunction

    task automatic observe(input ev_t got);
        ev_t want;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            want = exp_q.pop_front();
            check("event", got, want);
        end
    endtask

    always @(negedge clk) begin
        ev_t got;
        if (!rst) begin
            if (err_parity || err_frame || err_code || overrun) begin
                got      = '0;
                got.kind = 1'b1;
                got.errs = {err_parity, err_frame, err_code, overrun};
                observe(got);
            end
            if (out_valid && out_ready) begin
                got      = '0;
                got.seg  = seg_code;
                got.free = free_cnt;
                got.busy = busy_cnt;
                observe(got);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        seg_in = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 6; i >= 0; i--) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst       = 1'b1;
        seg_in    = 1'b1;
        out_ready = 1'b1;
        tick(3);
        check("rst_out_valid", 18'(out_valid), 18'd0);
        check("rst_seg_code", 18'(seg_code), 18'd0);
        check("rst_free_cnt", 18'(free_cnt), 18'd0);
        check("rst_busy_cnt", 18'(busy_cnt), 18'd0);
        check("rst_pulses", 18'({err_parity, err_frame, err_code, overrun}), 18'd0);
        rst = 1'b0;
        tick(4);

        // Good frames, ready held high.
        exp_q.push_back(res_ev(7'b1111110, 3'd0));
        send_frame(7'b1111110, 1'b0, 1'b1);
        tick(8);
        exp_q.push_back(res_ev(7'b1011011, 3'd5));
        send_frame(7'b1011011, 1'b1, 1'b1);
        tick(8);

        // Error frames.
        exp_q.push_back(err_ev(4'b1000));
        send_frame(7'b1011011, 1'b0, 1'b1);
        tick(8);
        exp_q.push_back(err_ev(4'b0010));
        send_frame(7'b1110000, 1'b1, 1'b1);
        tick(8);
        exp_q.push_back(err_ev(4'b0100));
        send_frame(7'b0110011, 1'b0, 1'b0);
        tick(20);  // line stays low: must not start another frame
        seg_in = 1'b1;
        tick(8);
        exp_q.push_back(err_ev(4'b1100));
        send_frame(7'b0110000, 1'b1, 1'b0);
        tick(20);
        seg_in = 1'b1;
        tick(8);

        // Overrun with consumer stalled.
        out_ready = 1'b0;
        exp_q.push_back(err_ev(4'b0001));
        exp_q.push_back(res_ev(7'b0110000, 3'd1));
        send_frame(7'b0110000, 1'b0, 1'b1);
        send_frame(7'b1101101, 1'b1, 1'b1);
        tick(8);
        check("hold_valid", 18'(out_valid), 18'd1);
        check("hold_free_cnt", 18'(free_cnt), 18'd1);
        check("hold_seg_code", 18'(seg_code), 18'(7'b0110000));
        out_ready = 1'b1;
        tick(1);
        check("drop_valid", 18'(out_valid), 18'd0);
        tick(4);

        // Glitch on idle line.
        seg_in = 1'b0;
        tick(1);
        seg_in = 1'b1;
        tick(20);

        // Reset during data bit 3 of 1111001.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        seg_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(10);
        check("midrst_valid", 18'(out_valid), 18'd0);
        check("midrst_seg_code", 18'(seg_code), 18'd0);
        exp_q.push_back(res_ev(7'b1111001, 3'd3));
        send_frame(7'b1111001, 1'b1, 1'b1);
        tick(10);

        check("queue_empty", 18'(exp_q.size()), 18'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
